// File: rtl/seq_controller_pkg.sv
// seq_controller_pkg: ctrl bit indices, instruction classes, phase indices and class decode
package seq_controller_pkg;
  localparam int CTRL_W = 28;
  localparam int B_HALT = 0;
  localparam int B_LOAD = 9;
  localparam int B_STORE = 10;
  localparam int B_LOADI = 11;
  localparam int B_MOV = 14;
  localparam int B_CMP = 23;
  localparam logic [CTRL_W-1:0] M_MEM_ALU = 28'h000007E;
  localparam logic [CTRL_W-1:0] M_REG_ALU = 28'h07FB180;
  localparam logic [CTRL_W-1:0] M_JMP = 28'hF000000;
  localparam logic [2:0] T0 = 3'd0;
  localparam logic [2:0] T1 = 3'd1;
  localparam logic [2:0] T2 = 3'd2;
  localparam logic [2:0] T3 = 3'd3;
  localparam logic [2:0] T4 = 3'd4;
  localparam logic [2:0] T5 = 3'd5;
  localparam logic [2:0] T6 = 3'd6;
  localparam logic [2:0] T7 = 3'd7;
  typedef enum logic [3:0] {
    C_NOP, C_HALT, C_MEM, C_LOAD, C_STORE, C_LOADI, C_REG, C_CMP, C_MOV, C_JMP, C_ILL
  } cls_t;
  typedef enum logic {S_RUN, S_HALTED} run_t;
  // c & (c-1) is nonzero exactly when more than one bit is set
  function automatic cls_t decode(input logic [CTRL_W-1:0] c);
    return ((c & (c - 28'd1)) != '0) ? C_ILL :
           c[B_HALT]                 ? C_HALT :
           |(c & M_MEM_ALU)          ? C_MEM :
           c[B_LOAD]                 ? C_LOAD :
           c[B_STORE]                ? C_STORE :
           c[B_LOADI]                ? C_LOADI :
           |(c & M_REG_ALU)          ? C_REG :
           c[B_CMP]                  ? C_CMP :
           c[B_MOV]                  ? C_MOV :
           |(c & M_JMP)              ? C_JMP : C_NOP;
  endfunction
endpackage

// File: rtl/seq_controller_if.sv
// seq_controller_if: instruction/handshake inputs and datapath strobe outputs of the sequencer
interface seq_controller_if #(parameter int NREG = 4);
  logic [27:0] ctrl;
  logic [NREG-1:0] tgt1, tgt2;
  logic mem_ready;
  logic [7:0] t_state;
  logic [NREG-1:0] reg_in, reg_out;
  logic alu_en, flag_we, mem_wr, pc_inc, pc_load, mar_load, ir_load, mar_from_bus, dtb_en;
  logic instr_done, illegal, halted;
  modport master (
    output ctrl, tgt1, tgt2, mem_ready,
    input t_state, reg_in, reg_out, alu_en, flag_we, mem_wr, pc_inc, pc_load, mar_load,
    input ir_load, mar_from_bus, dtb_en, instr_done, illegal, halted
  );
  modport slave (
    input ctrl, tgt1, tgt2, mem_ready,
    output t_state, reg_in, reg_out, alu_en, flag_we, mem_wr, pc_inc, pc_load, mar_load,
    output ir_load, mar_from_bus, dtb_en, instr_done, illegal, halted
  );
endinterface

// File: rtl/seq_controller_phase_gen.sv
// seq_phase_gen: phase index register, memory stall hold and HALTED state
module seq_phase_gen
  import seq_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       mem_phase,
  input  logic       mem_ready,
  input  logic       halt_req,
  input  logic [2:0] nxt,
  output logic [2:0] ph,
  output logic [7:0] t_state,
  output logic       halted,
  output logic       stall
);
  run_t st, st_nx;
  logic [2:0] ph_nx;
  assign halted = st == S_HALTED;
  assign stall = !halted && mem_phase && !mem_ready;
  assign t_state = halted ? 8'h00 : 8'h01 << ph;
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= S_RUN;
      ph <= T0;
    end else begin
      st <= st_nx;
      ph <= ph_nx;
    end
  end
  always_comb begin
    st_nx = st;
    ph_nx = ph;
    if (!halted && !stall) begin
      st_nx = halt_req ? S_HALTED : S_RUN;
      ph_nx = halt_req ? T0 : nxt;
    end
  end
endmodule

// File: rtl/seq_controller.sv
// seq_controller: T0..T7 instruction sequencer decoding ctrl classes into datapath strobes
module seq_controller
  import seq_controller_pkg::*;
#(
  parameter int NREG = 4,
  parameter bit FAST = 1'b1
) (
  input logic clk,
  input logic rst,
  seq_controller_if.slave bus
);
  cls_t cls;
  logic [2:0] ph, nxt;
  logic [7:0] t;
  logic mem_phase, halted, stall, mt, ls, halt_req, g;
  seq_phase_gen u_phase (
    .clk(clk),
    .rst(rst),
    .mem_phase(mem_phase),
    .mem_ready(bus.mem_ready),
    .halt_req(halt_req),
    .nxt(nxt),
    .ph(ph),
    .t_state(t),
    .halted(halted),
    .stall(stall)
  );
  assign cls = decode(bus.ctrl);
  assign mt = cls inside {C_MEM, C_LOAD, C_STORE, C_LOADI};
  assign ls = cls inside {C_LOAD, C_STORE};
  assign mem_phase = ph == T2 || (ph == T5 && mt) || (ph == T6 && ls);
  assign halt_req = t[3] && cls == C_HALT;
  assign g = !stall;
  // FAST skips the phases a class never uses; otherwise every class walks T0..T7
  always_comb begin
    nxt = ph + 3'd1;
    if (ph == T3)
      nxt = (cls == C_ILL || (FAST && cls == C_NOP)) ? T0 :
            (FAST && cls inside {C_REG, C_CMP, C_JMP}) ? T6 : T4;
    else if (ph == T4 && FAST && cls == C_MOV)
      nxt = T0;
    else if (ph == T6 && FAST && cls == C_JMP)
      nxt = T0;
  end
  assign bus.t_state = t;
  assign bus.halted = halted;
  assign bus.illegal = t[3] && cls == C_ILL;
  assign bus.mar_load = g && (t[0] || (t[3] && mt));
  assign bus.ir_load = g && t[2];
  assign bus.pc_inc = g && (t[2] || (t[5] && mt));
  assign bus.mar_from_bus = g && t[5] && ls;
  assign bus.dtb_en = t[0] || t[2] || (t[5] && cls == C_LOADI) || (t[6] && cls == C_LOAD) || stall;
  assign bus.alu_en = t[6] && cls inside {C_MEM, C_REG, C_CMP, C_JMP};
  assign bus.pc_load = g && t[6] && cls == C_JMP;
  assign bus.mem_wr = g && t[6] && cls == C_STORE;
  assign bus.flag_we = g && t[7] && cls inside {C_MEM, C_REG, C_CMP};
  assign bus.reg_out = (t[3] && cls == C_MOV) ? bus.tgt2 :
                       (t[6] && cls == C_STORE) ? bus.tgt1 : {NREG{1'b0}};
  assign bus.reg_in = (g && ((t[4] && cls == C_MOV) || (t[6] && cls == C_LOADI) ||
                      (t[7] && cls inside {C_MEM, C_LOAD, C_REG}))) ? bus.tgt1 : {NREG{1'b0}};
  assign bus.instr_done = g && (t[7] || (FAST && ((t[3] && cls == C_NOP) ||
                          (t[4] && cls == C_MOV) || (t[6] && cls == C_JMP))));
endmodule

// File: tb/tb_seq_controller.sv
// tb_seq_controller: directed vector table for FAST=1 plus a hand-written FAST=0 walk
module tb_seq_controller;
  localparam logic [27:0] ADD = 28'h0000008, RALU = 28'h0008000, LD = 28'h0000200;
  localparam logic [27:0] ST = 28'h0000400, LDI = 28'h0000800, MOV = 28'h0004000;
  localparam logic [27:0] CMP = 28'h0800000, JMP = 28'h1000000, HALT = 28'h0000001;
  localparam logic [27:0] BAD = 28'h0008008, NOP = 28'h0000000;
  localparam logic [11:0] S_ALU = 12'h800, S_FLAG = 12'h400, S_MWR = 12'h200, S_PCI = 12'h100;
  localparam logic [11:0] S_PCL = 12'h080, S_MARL = 12'h040, S_IRL = 12'h020, S_MFB = 12'h010;
  localparam logic [11:0] S_DTB = 12'h008, S_DONE = 12'h004, S_ILL = 12'h002, S_HLT = 12'h001;
  typedef struct {
    logic r;
    logic [27:0] c;
    logic [3:0] t1, t2;
    logic mr;
    logic [27:0] exp;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, rst0 = 1'b1;
  int checks = 0, errors = 0;
  vec_t v[$];
  logic [27:0] e0[$];
  logic [27:0] cur_c;
  logic [3:0] cur_t1, cur_t2;
  logic [27:0] act, act0;
  always #5 clk = ~clk;
  seq_controller_if #(.NREG(4)) bus ();
  seq_controller_if #(.NREG(4)) bus0 ();
  seq_controller #(.NREG(4), .FAST(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));
  seq_controller #(.NREG(4), .FAST(1'b0)) dut0 (.clk(clk), .rst(rst0), .bus(bus0));
  assign act = {bus.t_state, bus.reg_in, bus.reg_out, bus.alu_en, bus.flag_we, bus.mem_wr,
                bus.pc_inc, bus.pc_load, bus.mar_load, bus.ir_load, bus.mar_from_bus,
                bus.dtb_en, bus.instr_done, bus.illegal, bus.halted};
  assign act0 = {bus0.t_state, bus0.reg_in, bus0.reg_out, bus0.alu_en, bus0.flag_we, bus0.mem_wr,
                 bus0.pc_inc, bus0.pc_load, bus0.mar_load, bus0.ir_load, bus0.mar_from_bus,
                 bus0.dtb_en, bus0.instr_done, bus0.illegal, bus0.halted};
  task automatic ph(input logic r, input logic mr, input logic [7:0] ts, input logic [3:0] ri,
                    input logic [3:0] ro, input logic [11:0] s);
    v.push_back('{r, cur_c, cur_t1, cur_t2, mr, {ts, ri, ro, s}});
  endtask
  task automatic ins(input logic [27:0] c, input logic [3:0] t1, input logic [3:0] t2);
    cur_c = c;
    cur_t1 = t1;
    cur_t2 = t2;
    ph(0, 1, 8'h01, 0, 0, S_MARL | S_DTB);
    ph(0, 1, 8'h02, 0, 0, 0);
    ph(0, 1, 8'h04, 0, 0, S_IRL | S_PCI | S_DTB);
  endtask
  task automatic chk(input string nm, input int i, input logic [27:0] a, input logic [27:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s[%0d]: got ts=%h rin=%h rout=%h strb=%h, expected ts=%h rin=%h rout=%h strb=%h",
               nm, i, a[27:20], a[19:16], a[15:12], a[11:0], e[27:20], e[19:16], e[15:12], e[11:0]);
    end
  endtask
  initial begin
    ins(ADD, 4'b0010, 0);
    ph(0, 1, 8'h08, 0, 0, S_MARL);
    ph(0, 1, 8'h10, 0, 0, 0);
    ph(0, 1, 8'h20, 0, 0, S_PCI);
    ph(0, 1, 8'h40, 0, 0, S_ALU);
    ph(0, 1, 8'h80, 4'b0010, 0, S_FLAG | S_DONE);
    ins(RALU, 4'b0100, 0);
    ph(0, 1, 8'h08, 0, 0, 0);
    ph(0, 1, 8'h40, 0, 0, S_ALU);
    ph(0, 1, 8'h80, 4'b0100, 0, S_FLAG | S_DONE);
    ins(LD, 4'b0001, 0);
    ph(0, 1, 8'h08, 0, 0, S_MARL);
    ph(0, 1, 8'h10, 0, 0, 0);
    for (int i = 0; i < 3; i++) ph(0, 0, 8'h20, 0, 0, S_DTB);
    ph(0, 1, 8'h20, 0, 0, S_PCI | S_MFB);
    ph(0, 1, 8'h40, 0, 0, S_DTB);
    ph(0, 1, 8'h80, 4'b0001, 0, S_DONE);
    cur_c = ST;
    cur_t1 = 4'b1000;
    ph(0, 1, 8'h01, 0, 0, S_MARL | S_DTB);
    ph(0, 1, 8'h02, 0, 0, 0);
    ph(0, 0, 8'h04, 0, 0, S_DTB);
    ph(0, 1, 8'h04, 0, 0, S_IRL | S_PCI | S_DTB);
    ph(0, 1, 8'h08, 0, 0, S_MARL);
    ph(0, 1, 8'h10, 0, 0, 0);
    ph(0, 1, 8'h20, 0, 0, S_PCI | S_MFB);
    ph(0, 0, 8'h40, 0, 4'b1000, S_DTB);
    ph(0, 1, 8'h40, 0, 4'b1000, S_MWR);
    ph(0, 1, 8'h80, 0, 0, S_DONE);
    ins(MOV, 4'b0001, 4'b0100);
    ph(0, 1, 8'h08, 0, 4'b0100, 0);
    ph(0, 1, 8'h10, 4'b0001, 0, S_DONE);
    ins(LDI, 4'b0010, 0);
    ph(0, 1, 8'h08, 0, 0, S_MARL);
    ph(0, 1, 8'h10, 0, 0, 0);
    ph(0, 1, 8'h20, 0, 0, S_PCI | S_DTB);
    ph(0, 1, 8'h40, 4'b0010, 0, 0);
    ph(0, 1, 8'h80, 0, 0, S_DONE);
    ins(CMP, 4'b0010, 0);
    ph(0, 1, 8'h08, 0, 0, 0);
    ph(0, 1, 8'h40, 0, 0, S_ALU);
    ph(0, 1, 8'h80, 0, 0, S_FLAG | S_DONE);
    ins(JMP, 0, 0);
    ph(0, 1, 8'h08, 0, 0, 0);
    ph(0, 1, 8'h40, 0, 0, S_ALU | S_PCL | S_DONE);
    ins(NOP, 0, 0);
    ph(0, 1, 8'h08, 0, 0, S_DONE);
    ins(BAD, 4'b0010, 0);
    ph(0, 1, 8'h08, 0, 0, S_ILL);
    ins(JMP, 0, 0);
    ph(0, 1, 8'h08, 0, 0, 0);
    ph(1, 1, 8'h40, 0, 0, S_ALU | S_PCL | S_DONE);
    ins(LD, 4'b0001, 0);
    ph(0, 1, 8'h08, 0, 0, S_MARL);
    ph(0, 1, 8'h10, 0, 0, 0);
    ph(0, 0, 8'h20, 0, 0, S_DTB);
    ph(1, 0, 8'h20, 0, 0, S_DTB);
    ins(HALT, 0, 0);
    ph(0, 1, 8'h08, 0, 0, 0);
    for (int i = 0; i < 10; i++) ph(0, i[0], 8'h00, 0, 0, S_HLT);
    ph(1, 1, 8'h00, 0, 0, S_HLT);
    ins(NOP, 0, 0);
    ph(0, 1, 8'h08, 0, 0, S_DONE);
    for (int i = 0; i < 16; i++) begin
      if (i % 8 == 0) e0.push_back({8'h01, 8'h00, S_MARL | S_DTB});
      if (i % 8 == 1) e0.push_back({8'h02, 8'h00, 12'h000});
      if (i % 8 == 2) e0.push_back({8'h04, 8'h00, S_IRL | S_PCI | S_DTB});
      if (i % 8 == 3 || i % 8 == 4 || i % 8 == 5) e0.push_back({8'h08 << (i % 8 - 3), 8'h00, 12'h000});
      if (i == 6) e0.push_back({8'h40, 8'h00, S_ALU});
      if (i == 14) e0.push_back({8'h40, 8'h00, 12'h000});
      if (i == 7) e0.push_back({8'h80, 4'b0100, 4'h0, S_FLAG | S_DONE});
      if (i == 15) e0.push_back({8'h80, 8'h00, S_DONE});
    end
    e0.push_back({8'h01, 8'h00, S_MARL | S_DTB});
    bus.ctrl = NOP;
    bus.tgt1 = 0;
    bus.tgt2 = 0;
    bus.mem_ready = 1'b1;
    bus0.ctrl = RALU;
    bus0.tgt1 = 4'b0100;
    bus0.tgt2 = 0;
    bus0.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    foreach (v[i]) begin
      @(negedge clk);
      rst = v[i].r;
      bus.ctrl = v[i].c;
      bus.tgt1 = v[i].t1;
      bus.tgt2 = v[i].t2;
      bus.mem_ready = v[i].mr;
      #1;
      chk("fast", i, act, v[i].exp);
    end
    foreach (e0[i]) begin
      @(negedge clk);
      rst0 = 1'b0;
      bus0.ctrl = (i < 8) ? RALU : NOP;
      #1;
      chk("full", i, act0, e0[i]);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_controller.md
SEQ_CONTROLLER -- requirements
Module: seq_controller

Interface
REQ-001 Parameter NREG, default 4, number of general registers; each register gets one load strobe and one drive strobe.
REQ-002 Parameter FAST, default 1: 1 skips unused phases; 0 always runs the full T0..T7 sequence.
REQ-003 clk  in  1  the block's single clock; all state changes on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 ctrl  in  28  one-hot instruction decode from IR; valid from T3 until instr_done.
REQ-006 tgt1, tgt2  in  NREG each  one-hot destination / source register selects; valid with ctrl.
REQ-007 mem_ready  in  1  memory handshake; low stalls memory phases.
REQ-008 t_state  out  8  one-hot current phase T0..T7; all-zero when halted.
REQ-009 reg_in, reg_out  out  NREG each  register load / bus-drive strobes.
REQ-010 alu_en, flag_we, mem_wr, pc_inc, pc_load, mar_load, ir_load, mar_from_bus, dtb_en  out  1 each  datapath strobes.
REQ-011 instr_done, illegal, halted  out  1 each  status.

Function
REQ-012 Classes from ctrl: HALT=bit0; MEM_ALU=bits1-6; LOAD=9; STORE=10; LOADI=11; REG_ALU=7,8,12,13,15-22; CMP=23; MOV=14; JMP=24-27; bits 1..27 none set = NOP.
REQ-013 Phase counter SHALL hold a 3-bit index; t_state is its one-hot decode.
REQ-014 T0-T3 always run: T0 mar_load+dtb_en; T1 idle; T2 ir_load+pc_inc+dtb_en; T3 decode.
REQ-015 FAST=1 sequences after T3: MEM_ALU/LOAD/STORE/LOADI T4..T7; REG_ALU/CMP T6,T7; MOV T4 then T0; JMP T6 then T0; NOP T0.
REQ-016 FAST=0: every class runs T0..T7; strobes fire only in the phases listed for that class.
REQ-017 Memory phases are T2 (all instructions), T5 for MEM_ALU/LOAD/STORE/LOADI, and T6 for LOAD/STORE.
REQ-018 In a memory phase with mem_ready=0, the phase SHALL hold and dtb_en stays asserted; all load strobes and mem_wr are gated off until mem_ready=1.
REQ-019 T3 strobes: MEM_ALU/LOAD/STORE/LOADI assert mar_load; MOV asserts reg_out=tgt2.
REQ-020 T4 strobes: MOV asserts reg_in=tgt1.
REQ-021 T5 strobes: MEM_ALU/LOAD/STORE/LOADI assert pc_inc; LOAD/STORE assert mar_from_bus; LOADI asserts dtb_en.
REQ-022 T6 strobes: alu_en for MEM_ALU/REG_ALU/CMP/JMP; pc_load for JMP; STORE asserts reg_out=tgt1 and mem_wr; LOADI asserts reg_in=tgt1; LOAD asserts dtb_en.
REQ-023 T7 strobes: reg_in=tgt1 for MEM_ALU/LOAD/REG_ALU except CMP; flag_we for MEM_ALU/REG_ALU/CMP.
REQ-024 instr_done SHALL pulse for one cycle in the last phase of each instruction, on its completing (non-stalled) cycle.
REQ-025 More than one ctrl bit set at T3: illegal pulses one cycle, no further strobes, next phase T0 (NOP).
REQ-026 HALT at T3 enters HALTED: halted=1, t_state=0, all strobes 0 until rst.
REQ-027 Phase index wraps T7->T0 via the class sequence only; no other transition exists.

Reset
REQ-028 rst SHALL force phase T0 and halted=0 with all strobes 0 except T0 strobes, including mid-stall and mid-instruction.
REQ-029 The first instruction starts the cycle after rst deasserts.

Structure
REQ-030 A shared package SHALL hold the ctrl bit-index constants, the class enum, and the phase-index constants.
REQ-031 One sub-module seq_phase_gen SHALL hold the phase counter, stall, and HALTED state; the top level decodes classes and strobes.

Verification
REQ-032 ADD mem (ctrl bit3, tgt1=0010), FAST=1, mem_ready=1 -> 8 cycles T0..T7; reg_in=0010 at T7; flag_we at T7; instr_done at T7.
REQ-033 REG_ALU (ctrl bit15), FAST=1 -> t_state sequence 01,02,04,08,40,80; FAST=0 -> 8 phases, with no strobes in T4/T5.
REQ-034 LOAD with mem_ready=0 for 3 cycles in T5 -> T5 held 4 cycles; pc_inc asserted exactly once.
REQ-035 ctrl=bits 3 and 15 set -> illegal pulse at T3; next cycle t_state=01.
REQ-036 HALT -> halted=1 and t_state=00 held 10 cycles; rst pulse -> t_state=01, halted=0.
REQ-037 rst asserted during JMP T6 -> pc_load deasserts the next cycle and t_state=01.
